// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered results and flags.
// Single-cycle ops: ADD SUB AND OR XOR SHL SHR. MUL (shift-add) and DIV
// (restoring) take WIDTH iterations and exist only when the macro
// ALU_SEQ_MULDIV_EN is defined. Without that macro, opcodes 2 and 3 are
// reported as illegal.
//
// Handshake: a command transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready. Once
// out_valid is asserted, alu_out, alu_out_hi and the flags stay stable until
// that transfer. The block does not accept a new command on the edge where it
// hands off a result.
//
// The FSM state is held in the signal 'state' (IDLE/BUSY/DONE), and a checker
// can bind to it directly.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             zero_flag,
  output logic             err_flag
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] c_lo;
  logic [WIDTH-1:0] c_hi;
  logic             c_carry;
  logic             c_ovf;
  logic             c_err;

  assign add_full = {1'b0, data_a} + {1'b0, data_b};
  assign sub_full = {1'b0, data_a} - {1'b0, data_b};
  assign shamt    = data_b[SHW-1:0];
  assign in_ready = (state == IDLE);

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic             c_start;
  logic             is_div;
  logic [WIDTH-1:0] operand;   // a for MUL, divisor b for DIV
  logic [WIDTH-1:0] work_hi;   // product high / partial remainder
  logic [WIDTH-1:0] work_lo;   // multiplier bits / dividend-quotient bits
  logic [CW-1:0]    count;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] n_hi;
  logic [WIDTH-1:0] n_lo;

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : '0);
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    n_hi      = mul_sum[WIDTH:1];
    n_lo      = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (is_div) begin
      // Top bit of the trial difference set means the subtraction went negative.
      if (!div_trial[WIDTH]) begin
        n_hi = div_trial[WIDTH-1:0];
        n_lo = {work_lo[WIDTH-2:0], 1'b1};
      end else begin
        n_hi = div_shift[WIDTH-1:0];
        n_lo = {work_lo[WIDTH-2:0], 1'b0};
      end
    end
  end
`endif

  // Single-cycle result and flags for the opcode currently on the inputs
  always_comb begin
    c_lo    = '0;
    c_hi    = '0;
    c_carry = 1'b0;
    c_ovf   = 1'b0;
    c_err   = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    c_start = 1'b0;
`endif
    case (alu_sel)
      4'd0: begin
        c_lo    = add_full[WIDTH-1:0];
        c_carry = add_full[WIDTH];
        c_ovf   = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                  (add_full[WIDTH-1] != data_a[WIDTH-1]);
      end
      4'd1: begin
        c_lo    = sub_full[WIDTH-1:0];
        c_carry = sub_full[WIDTH];  // borrow, i.e. a < b
        c_ovf   = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != data_a[WIDTH-1]);
      end
`ifdef ALU_SEQ_MULDIV_EN
      4'd2: c_start = 1'b1;
      4'd3: begin
        if (data_b == '0) begin
          c_lo  = '1;
          c_hi  = data_a;
          c_err = 1'b1;
        end else begin
          c_start = 1'b1;
        end
      end
`endif
      4'd4: c_lo = data_a & data_b;
      4'd5: c_lo = data_a | data_b;
      4'd6: c_lo = data_a ^ data_b;
      4'd7: c_lo = data_a << shamt;
      4'd8: c_lo = data_a >> shamt;
      default: c_err = 1'b1;
    endcase
  end

  // Control FSM plus the registered result and flag outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      alu_out    <= '0;
      alu_out_hi <= '0;
      carry_flag <= 1'b0;
      ovf_flag   <= 1'b0;
      zero_flag  <= 1'b0;
      err_flag   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      is_div     <= 1'b0;
      operand    <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
      count      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (c_start) begin
              state   <= BUSY;
              count   <= CW'(WIDTH);
              is_div  <= (alu_sel == 4'd3);
              // MUL: multiplier shifts out of work_lo, a is added.
              // DIV: dividend shifts out of work_lo, b is subtracted.
              operand <= (alu_sel == 4'd3) ? data_b : data_a;
              work_hi <= '0;
              work_lo <= (alu_sel == 4'd3) ? data_a : data_b;
            end else
`endif
            begin
              state      <= DONE;
              out_valid  <= 1'b1;
              alu_out    <= c_lo;
              alu_out_hi <= c_hi;
              carry_flag <= c_carry;
              ovf_flag   <= c_ovf;
              zero_flag  <= (c_lo == '0);
              err_flag   <= c_err;
            end
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          work_hi <= n_hi;
          work_lo <= n_lo;
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            alu_out    <= n_lo;
            alu_out_hi <= n_hi;
            carry_flag <= 1'b0;
            ovf_flag   <= 1'b0;
            zero_flag  <= (n_lo == '0);
            err_flag   <= 1'b0;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus hand-written multi-cycle sequences
// for alu_seq at WIDTH=8. Expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic [3:0]   alu_sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [W-1:0] alu_out_hi;
  logic         carry_flag;
  logic         ovf_flag;
  logic         zero_flag;
  logic         err_flag;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .carry_flag(carry_flag), .ovf_flag(ovf_flag),
    .zero_flag(zero_flag), .err_flag(err_flag)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Flags packed as {carry, ovf, zero, err}
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   flags;
    int           lat;
    string        name;
  } vec_t;

  vec_t vecs[$];
  logic [2*W+3:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                         input logic [W-1:0] lo, input logic [W-1:0] hi,
                         input logic [3:0] flags, input int lat, input string name);
    vec_t v;
    v.a = a; v.b = b; v.sel = sel; v.lo = lo; v.hi = hi;
    v.flags = flags; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] cur_flags();
    return {carry_flag, ovf_flag, zero_flag, err_flag};
  endfunction

  // Driver: issue one command, time the result, score it, optionally stall.
  task automatic run_op(input vec_t v, input int hold);
    logic [2*W+3:0] e;
    logic [2*W+3:0] snap;
    logic           held_ok;
    int             lat;
    @(negedge clk);
    check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
    data_a    = v.a;
    data_b    = v.b;
    alu_sel   = v.sel;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back({v.hi, v.lo, v.flags});
    @(negedge clk);
    in_valid = 1'b0;
    data_a   = W'($urandom_range(0, 255));
    data_b   = W'($urandom_range(0, 255));
    alu_sel  = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    e = exp_q.pop_front();
    check({v.name, " lo"}, 32'(alu_out), 32'(e[W+3:4]));
    check({v.name, " hi"}, 32'(alu_out_hi), 32'(e[2*W+3:W+4]));
    check({v.name, " flags"}, 32'(cur_flags()), 32'(e[3:0]));
    if (hold > 0) begin
      snap = {alu_out_hi, alu_out, cur_flags()};
      held_ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if ({alu_out_hi, alu_out, cur_flags()} !== snap || !out_valid || in_ready)
          held_ok = 1'b0;
      end
      check({v.name, " hold stable"}, 32'(held_ok), 32'd1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    check({v.name, " released"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  // Sequence: command accepted, then reset while BUSY or DONE; no result may follow.
  task automatic reset_abort(input logic [3:0] sel, input int wait_cycles, input string name);
    logic seen;
    @(negedge clk);
    data_a    = 8'd200;
    data_b    = 8'd3;
    alu_sel   = sel;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (wait_cycles) @(negedge clk);
    reset = 1'b1;
    #1;
    check({name, " outs zero"},
          32'({alu_out, alu_out_hi, carry_flag, ovf_flag, zero_flag, err_flag, out_valid}), 32'd0);
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check({name, " no out_valid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_a    = '0;
    data_b    = '0;
    alu_sel   = '0;

    // Single-cycle ops
    add_vec(8'hF0, 8'h20, 4'd0, 8'h10, 8'h00, 4'b1000, 1, "add carry");
    add_vec(8'h70, 8'h10, 4'd0, 8'h80, 8'h00, 4'b0100, 1, "add ovf");
    add_vec(8'hFF, 8'h01, 4'd0, 8'h00, 8'h00, 4'b1010, 1, "add wrap zero");
    add_vec(8'h05, 8'h07, 4'd1, 8'hFE, 8'h00, 4'b1000, 1, "sub borrow");
    add_vec(8'h07, 8'h07, 4'd1, 8'h00, 8'h00, 4'b0010, 1, "sub zero");
    add_vec(8'h80, 8'h01, 4'd1, 8'h7F, 8'h00, 4'b0100, 1, "sub ovf");
    add_vec(8'hF0, 8'h3C, 4'd4, 8'h30, 8'h00, 4'b0000, 1, "and");
    add_vec(8'hF0, 8'h0F, 4'd5, 8'hFF, 8'h00, 4'b0000, 1, "or");
    add_vec(8'hAA, 8'hAA, 4'd6, 8'h00, 8'h00, 4'b0010, 1, "xor zero");
    add_vec(8'h01, 8'h07, 4'd7, 8'h80, 8'h00, 4'b0000, 1, "shl 7");
    add_vec(8'h81, 8'h09, 4'd7, 8'h02, 8'h00, 4'b0000, 1, "shl masked");
    add_vec(8'h80, 8'h03, 4'd8, 8'h10, 8'h00, 4'b0000, 1, "shr");
    add_vec(8'h55, 8'h33, 4'd12, 8'h00, 8'h00, 4'b0011, 1, "illegal 12");
    add_vec(8'hFF, 8'hFF, 4'd15, 8'h00, 8'h00, 4'b0011, 1, "illegal 15");
`ifdef ALU_SEQ_MULDIV_EN
    add_vec(8'hFF, 8'hFF, 4'd2, 8'h01, 8'hFE, 4'b0000, 9, "mul ff*ff");
    add_vec(8'd200, 8'd7, 4'd3, 8'd28, 8'd4, 4'b0000, 9, "div 200/7");
    add_vec(8'd5, 8'd9, 4'd3, 8'd0, 8'd5, 4'b0010, 9, "div 5/9");
    add_vec(8'd200, 8'd0, 4'd3, 8'hFF, 8'd200, 4'b0001, 1, "div by zero");
`else
    add_vec(8'd3, 8'd3, 4'd2, 8'h00, 8'h00, 4'b0011, 1, "mul disabled");
    add_vec(8'd200, 8'd7, 4'd3, 8'h00, 8'h00, 4'b0011, 1, "div disabled");
    add_vec(8'd200, 8'd0, 4'd3, 8'h00, 8'h00, 4'b0011, 1, "div0 disabled");
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outs",
          32'({alu_out, alu_out_hi, carry_flag, ovf_flag, zero_flag, err_flag, out_valid}), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0);

    // Stalled consumer: result must hold for 5 cycles with in_ready low
`ifdef ALU_SEQ_MULDIV_EN
    begin
      vec_t m;
      m.a = 8'd200; m.b = 8'd3; m.sel = 4'd2; m.lo = 8'h58; m.hi = 8'h02;
      m.flags = 4'b0000; m.lat = 9; m.name = "mul 200*3 stall";
      run_op(m, 5);
    end
    reset_abort(4'd2, 2, "reset mid-mul");
`else
    begin
      vec_t m;
      m.a = 8'hF0; m.b = 8'h20; m.sel = 4'd0; m.lo = 8'h10; m.hi = 8'h00;
      m.flags = 4'b1000; m.lat = 1; m.name = "add stall";
      run_op(m, 5);
    end
`endif
    reset_abort(4'd0, 2, "reset in done");

    // Back-to-back after the aborts still works
    run_op(vecs[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit registered ALU. It adds a configurable operand width, valid/ready flow control on both sides, iterative multi-cycle multiply and divide with full-width results, and a status flag set. It sits between an operand-issuing controller (switch/FSM front end) and the display/result register stage on the Basys3 datapath.

## Interface
- WIDTH, 8: operand and result word width; legal range 4..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset; clears all state.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block accepts a command this cycle.
- data_a  input  WIDTH  operand A (unsigned; signed view used only for overflow).
- data_b  input  WIDTH  operand B.
- alu_sel  input  4  opcode.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- alu_out  output  WIDTH  result low word / quotient.
- alu_out_hi  output  WIDTH  product high word / remainder; 0 for other ops.
- carry_flag  output  1  ADD carry-out, SUB borrow; 0 otherwise.
- ovf_flag  output  1  signed two's-complement overflow for ADD/SUB; 0 otherwise.
- zero_flag  output  1  alu_out == 0.
- err_flag  output  1  divide-by-zero or illegal/disabled opcode.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 SHL (a << b[$clog2(WIDTH)-1:0]), 8 SHR (logical). 9..15 illegal.
- States: IDLE, BUSY, DONE. in_ready = (state == IDLE).
- Accept on in_valid && in_ready: operands and opcode latched.
  - Single-cycle ops (ADD/SUB/AND/OR/XOR/SHL/SHR/illegal): result computed, IDLE -> DONE.
  - MUL, DIV with b != 0: IDLE -> BUSY, iteration counter loaded with WIDTH.
  - DIV with b == 0: IDLE -> DONE, alu_out = all ones, alu_out_hi = a, err_flag = 1.
- BUSY: MUL is shift-add, one bit per cycle; DIV is restoring, one quotient bit per cycle. Counter decrements; at 1 the result is written, BUSY -> DONE.
- MUL: {alu_out_hi, alu_out} = a * b (2*WIDTH bits, unsigned). DIV: alu_out = a / b, alu_out_hi = a % b.
- ADD: {carry, alu_out} = a + b (WIDTH+1 bits). SUB: alu_out = a - b mod 2^WIDTH, carry = (a < b).
- Illegal opcode: alu_out = 0, alu_out_hi = 0, err_flag = 1, zero_flag = 1.
- DONE: outputs held stable while out_ready is low. On out_valid && out_ready, DONE -> IDLE. No new accept in the same cycle.
- Outputs are registered and change only on the transition into DONE or on reset.

## Timing
- Reset: state IDLE, in_ready 1, out_valid 0, alu_out 0, alu_out_hi 0, all flags 0.
- Single-cycle op accepted at edge N: out_valid high after edge N+1 (latency 1).
- MUL/DIV accepted at edge N: out_valid high after edge N+WIDTH+1.
- Divide by zero: latency 1.
- Throughput (single-cycle ops, out_ready tied high): one op per 2 cycles.
- Reset asserted in BUSY or DONE aborts the operation; no out_valid is produced for it.
- Input signals are ignored whenever in_ready = 0.

## Configuration
- ALU_SEQ_MULDIV_EN defined: MUL and DIV are implemented as above.
- ALU_SEQ_MULDIV_EN undefined: no multiplier or divider datapath, and BUSY is never entered.
  - Opcodes 2 and 3 behave as illegal opcodes: latency 1, results 0, err_flag 1.

## Test plan
- Reset mid-MUL (WIDTH=8): accept MUL, assert reset at cycle 4 -> all outputs 0, in_ready 1, and no out_valid follows.
- ADD 0xF0 + 0x20 -> alu_out 0x10, carry 1, ovf 0, zero 0, out_valid 1 cycle after accept. ADD 0x70 + 0x10 -> 0x80, ovf 1, carry 0.
- SUB 0x05 - 0x07 -> alu_out 0xFE, carry 1, ovf 0. SUB 0x07 - 0x07 -> alu_out 0x00, zero 1.
- MUL 200 * 3 -> alu_out 0x58, alu_out_hi 0x02, out_valid exactly 9 cycles after accept. Hold out_ready low for 5 cycles -> outputs stable and in_ready 0 throughout.
- DIV 200 / 7 -> quotient 28, remainder 4, latency 9. DIV 200 / 0 -> alu_out 0xFF, alu_out_hi 200, err 1, latency 1.
- Opcode 12 -> alu_out 0, err 1, zero 1. With ALU_SEQ_MULDIV_EN undefined, MUL 3 * 3 -> alu_out 0, err 1, latency 1.
